peripheral_bin2bcd_multi: RTL and testbench
===========================================

// Module: peripheral_bin2bcd_multi
// PURPOSE
//  Memory-mapped binary-to-BCD converter; successor to the fixed 16-bit double peripheral.
//  Parametrised input width and digit count. Adds signed (sign-magnitude) mode, overflow
//  flag, read-to-clear done, and an interrupt line.
//  Sits on the 16-bit CPU peripheral bus (cs/addr/rd/wr) next to the other memory-mapped blocks.
// PARAMETERS
//  BIN_W   16  input width in bits, 4..32
//  DIGITS  5   BCD digits produced, 1..8
// PORTS
//  clk    in   1   system clock; all state updates on posedge
//  reset  in   1   asynchronous, active-low reset
//  d_in   in   16  bus write data
//  cs     in   1   chip select
//  addr   in   5   register address
//  rd     in   1   read strobe (qualified by cs)
//  wr     in   1   write strobe (qualified by cs)
//  d_out  out  16  bus read data, registered
//  irq    out  1   done & irq_en
// BEHAVIOUR
//  Register map:
//   - 0x04 W: DATA_LO <= d_in.
//   - 0x18 W: DATA_HI <= d_in[BIN_W-17:0]; present only when BIN_W>16.
//   - 0x08 W: CTRL. bit0 start (self-clearing pulse), bit1 signed, bit2 irq_en.
//     bits 1 and 2 are stored.
//   - 0x0C R: RES_LO = digits 3..0, digit0 in [3:0].
//   - 0x14 R: RES_HI = digits 7..4, zero-filled above DIGITS.
//   - 0x10 R: STATUS. bit0 done, bit1 busy, bit2 neg, bit3 ovf.
//  Bus reads:
//   - d_out updates at each posedge with cs&rd; valid the cycle after the address is presented.
//   - d_out = 0 otherwise, and for unmapped addresses.
//   - Writes to unmapped addresses are ignored.
//  Reset (reset=0, async):
//   - All registers, result, flags, d_out and irq go to 0; FSM goes to IDLE.
//   - Any conversion in progress is abandoned; no done is produced.
//  FSM IDLE -> CONV -> IDLE:
//   - Start write in IDLE at edge N: snapshot operand; busy=1 from N.
//   - CONV runs BIN_W double-dabble iterations, one per clk (add-3 on digits >=5, then shift).
//   - At edge N+BIN_W: result and flags are latched; busy=0; done=1.
//   - Start written while busy is ignored; CTRL bits 1/2 still update.
//   - DATA writes during CONV do not affect the running conversion (snapshot taken at start).
//  Signed mode (taken from CTRL.bit1 at start):
//   - If operand[BIN_W-1]=1: magnitude = two's-complement negation, neg=1.
//   - Otherwise neg=0. In unsigned mode neg=0.
//   - Most-negative value converts exactly (e.g. 0x8000 gives 32768).
//  Overflow:
//   - ovf=1 iff magnitude >= 10^DIGITS; the result then holds the low DIGITS digits.
//   - ovf is cleared at the next start.
//  done:
//   - Cleared by a STATUS read (the read returns done=1).
//   - If completion and a STATUS read fall on the same edge, set wins.
//   - A new start also clears done.
// STRUCTURE
//  Shared package bin2bcd_pkg:
//   - Address localparams (ADDR_DATA_LO, ADDR_CTRL, ADDR_RES_LO, ADDR_STATUS,
//     ADDR_RES_HI, ADDR_DATA_HI).
//   - CTRL/STATUS bit indices.
//   - FSM state encoding.
//  Sub-module bin2bcd_dd_core #(BIN_W,DIGITS):
//   - Ports: start, operand, busy, done_pulse, bcd, ovf.
//   - Holds the iteration counter and shift register.
//  Top level keeps the bus decode, registers and sign handling.
// TESTING
//  1. Write 0x04=12, 0x08=0x1; poll 0x10
//     -> busy for 16 cycles, then STATUS=0x0001, RES_LO=0x0012; second STATUS read =0x0000.
//  2. DATA=65535, start -> RES_LO=0x5535, RES_HI=0x0006, neg=0, ovf=0.
//  3. CTRL=0x3 with DATA=0xFFF4 -> RES_LO=0x0012, neg=1.
//     DATA=0x8000 -> RES_LO=0x2768, RES_HI=0x0003, neg=1.
//  4. DIGITS=4, DATA=12345, start -> ovf=1, RES_LO=0x2345.
//     Restart with DATA=9999 -> ovf=0, RES_LO=0x9999.
//  5. Start, then 5 cycles later write DATA=7 and start again
//     -> second start ignored; result equals the first operand; one done only.
//  6. Assert reset 8 cycles into a conversion
//     -> all outputs 0, no done/irq; a fresh start afterwards converts correctly.
//     Also with irq_en=1: irq rises with done and falls with the STATUS read.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// rtl/bin2bcd_pkg.sv - shared definitions for the binary-to-BCD peripheral
// Purpose: register addresses, CTRL/STATUS bit positions, conversion FSM
//          encoding and the per-digit add-3 helper used by the core.
// Ports:   none (package).
package bin2bcd_pkg;

  localparam logic [4:0] ADDR_DATA_LO = 5'h04;
  localparam logic [4:0] ADDR_CTRL    = 5'h08;
  localparam logic [4:0] ADDR_RES_LO  = 5'h0C;
  localparam logic [4:0] ADDR_STATUS  = 5'h10;
  localparam logic [4:0] ADDR_RES_HI  = 5'h14;
  localparam logic [4:0] ADDR_DATA_HI = 5'h18;

  localparam int CTRL_START  = 0;
  localparam int CTRL_SIGNED = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int STAT_DONE = 0;
  localparam int STAT_BUSY = 1;
  localparam int STAT_NEG  = 2;
  localparam int STAT_OVF  = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } conv_state_t;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/bin2bcd_dd_core.sv
// rtl/bin2bcd_dd_core.sv - sequential double-dabble converter, one bit per clock
// Purpose: converts an unsigned operand into DIGITS BCD digits over BIN_W cycles.
// Ports:   clk, reset (async, active-low)
//          start      - accepted only while idle; snapshots operand
//          operand    - unsigned magnitude to convert
//          busy       - high while iterating
//          done_pulse - high during the final iteration cycle (result lands on that edge)
//          bcd        - last completed result, low DIGITS digits
//          ovf        - last completed magnitude did not fit in DIGITS digits
module bin2bcd_dd_core
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_W-1:0]      operand,
  output logic                  busy,
  output logic                  done_pulse,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int BCD_W = 4 * DIGITS;

  conv_state_t      state, state_nxt;
  logic [BIN_W-1:0] bin_sr;
  logic [BCD_W-1:0] bcd_sr;
  logic [BCD_W-1:0] bcd_adj;
  logic [5:0]       iter;
  logic             ovf_sticky;
  logic             last_iter;

  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      bcd_adj[4*i +: 4] = add3(bcd_sr[4*i +: 4]);
    end
  end

  assign last_iter = (iter == 6'(BIN_W - 1));
  assign busy      = (state == ST_CONV);

  always_comb begin
    state_nxt  = state;
    done_pulse = 1'b0;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_CONV;
      ST_CONV: begin
        if (last_iter) begin
          state_nxt  = ST_IDLE;
          done_pulse = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // The BCD register is only DIGITS wide, so it holds the running value
  // modulo 10^DIGITS. Any bit carried out of the top digit means the true
  // value has reached 10^DIGITS, and it can only grow from there, so a
  // sticky flag of those carries is an exact overflow indication.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bin_sr     <= '0;
      bcd_sr     <= '0;
      iter       <= '0;
      ovf_sticky <= 1'b0;
      bcd        <= '0;
      ovf        <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (start) begin
        bin_sr     <= operand;
        bcd_sr     <= '0;
        iter       <= '0;
        ovf_sticky <= 1'b0;
        ovf        <= 1'b0;
      end
    end else begin
      {bcd_sr, bin_sr} <= {bcd_adj[BCD_W-2:0], bin_sr, 1'b0};
      iter             <= iter + 6'd1;
      ovf_sticky       <= ovf_sticky | bcd_adj[BCD_W-1];
      if (last_iter) begin
        bcd <= {bcd_adj[BCD_W-2:0], bin_sr[BIN_W-1]};
        ovf <= ovf_sticky | bcd_adj[BCD_W-1];
      end
    end
  end

endmodule

// File: rtl/peripheral_bin2bcd_multi.sv
// rtl/peripheral_bin2bcd_multi.sv - memory-mapped binary-to-BCD converter peripheral
// Purpose: bus decode, operand/control registers, sign handling and status
//          around the double-dabble core.
// Ports:   clk, reset (async, active-low)
//          d_in[15:0], cs, addr[4:0], rd, wr - peripheral bus inputs
//          d_out[15:0] - registered read data, zero when not reading
//          irq         - done & irq_en
module peripheral_bin2bcd_multi
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] d_in,
  input  logic        cs,
  input  logic [4:0]  addr,
  input  logic        rd,
  input  logic        wr,
  output logic [15:0] d_out,
  output logic        irq
);

  localparam int LO_W = (BIN_W < 16) ? BIN_W : 16;

  logic                wr_data_lo, wr_ctrl, rd_status, start_req, start_ok;
  logic [LO_W-1:0]     data_lo;
  logic [BIN_W-1:0]    data_full, magnitude;
  logic                ctrl_signed, ctrl_irq_en;
  logic                signed_sel, neg_now, neg_pend, neg, done;
  logic                busy, done_pulse, ovf;
  logic [4*DIGITS-1:0] bcd;
  logic [31:0]         bcd_pad;
  logic [15:0]         rd_mux;

  assign wr_data_lo = cs & wr & (addr == ADDR_DATA_LO);
  assign wr_ctrl    = cs & wr & (addr == ADDR_CTRL);
  assign rd_status  = cs & rd & (addr == ADDR_STATUS);
  assign start_req  = wr_ctrl & d_in[CTRL_START];
  assign start_ok   = start_req & ~busy;

  generate
    if (BIN_W > 16) begin : g_hi
      logic [BIN_W-17:0] data_hi;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                data_hi <= '0;
        else if (cs && wr && addr == ADDR_DATA_HI) data_hi <= d_in[BIN_W-17:0];
      end
      assign data_full = {data_hi, data_lo};
    end else begin : g_no_hi
      assign data_full = data_lo;
    end
  endgenerate

  // Signedness comes from the same CTRL write that carries the start bit.
  assign signed_sel = wr_ctrl ? d_in[CTRL_SIGNED] : ctrl_signed;
  assign neg_now    = signed_sel & data_full[BIN_W-1];
  assign magnitude  = neg_now ? (~data_full + 1'b1) : data_full;

  bin2bcd_dd_core #(
    .BIN_W  (BIN_W),
    .DIGITS (DIGITS)
  ) u_core (
    .clk        (clk),
    .reset      (reset),
    .start      (start_ok),
    .operand    (magnitude),
    .busy       (busy),
    .done_pulse (done_pulse),
    .bcd        (bcd),
    .ovf        (ovf)
  );

  always_comb begin
    bcd_pad                 = '0;
    bcd_pad[4*DIGITS-1:0]   = bcd;
  end

  always_comb begin
    rd_mux = '0;
    case (addr)
      ADDR_RES_LO: rd_mux = bcd_pad[15:0];
      ADDR_RES_HI: rd_mux = bcd_pad[31:16];
      ADDR_STATUS: rd_mux = {12'b0, ovf, neg, busy, done};
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_lo     <= '0;
      ctrl_signed <= 1'b0;
      ctrl_irq_en <= 1'b0;
      neg_pend    <= 1'b0;
      neg         <= 1'b0;
      done        <= 1'b0;
      d_out       <= '0;
    end else begin
      if (wr_data_lo) data_lo <= d_in[LO_W-1:0];
      if (wr_ctrl) begin
        ctrl_signed <= d_in[CTRL_SIGNED];
        ctrl_irq_en <= d_in[CTRL_IRQ_EN];
      end
      if (start_ok)   neg_pend <= neg_now;
      if (done_pulse) neg      <= neg_pend;
      // Completion outranks a coinciding STATUS read so no done is lost.
      if (done_pulse)                 done <= 1'b1;
      else if (start_ok || rd_status) done <= 1'b0;
      d_out <= (cs && rd) ? rd_mux : 16'h0000;
    end
  end

  assign irq = done & ctrl_irq_en;

endmodule

// File: tb/tb_peripheral_bin2bcd_multi.sv
// tb/tb_peripheral_bin2bcd_multi.sv - self-checking bench for peripheral_bin2bcd_multi
module tb_peripheral_bin2bcd_multi;

  localparam logic [4:0] A_DATA_LO = 5'h04;
  localparam logic [4:0] A_CTRL    = 5'h08;
  localparam logic [4:0] A_RES_LO  = 5'h0C;
  localparam logic [4:0] A_STATUS  = 5'h10;
  localparam logic [4:0] A_RES_HI  = 5'h14;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] d_in;
  logic        cs, rd, wr;
  logic [4:0]  addr;
  logic [15:0] d_out, d_out4;
  logic        irq, irq4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  peripheral_bin2bcd_multi #(.BIN_W(16), .DIGITS(5)) u_dut (
    .clk(clk), .reset(reset), .d_in(d_in), .cs(cs), .addr(addr),
    .rd(rd), .wr(wr), .d_out(d_out), .irq(irq)
  );

  peripheral_bin2bcd_multi #(.BIN_W(16), .DIGITS(4)) u_dut4 (
    .clk(clk), .reset(reset), .d_in(d_in), .cs(cs), .addr(addr),
    .rd(rd), .wr(wr), .d_out(d_out4), .irq(irq4)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic bus_write(input logic [4:0] a, input logic [15:0] v);
    cs = 1'b1; wr = 1'b1; addr = a; d_in = v;
    @(posedge clk); #1;
    cs = 1'b0; wr = 1'b0; d_in = '0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [15:0] v5, output logic [15:0] v4);
    cs = 1'b1; rd = 1'b1; addr = a;
    @(posedge clk); #1;
    v5 = d_out; v4 = d_out4;
    cs = 1'b0; rd = 1'b0;
  endtask

  // Reference: arithmetic conversion from the behavioural rules.
  task automatic model(input int unsigned v, input bit sgn, input int digits,
                       output logic [15:0] lo, output logic [15:0] hi, output logic [15:0] st);
    int unsigned mag, p10, r;
    bit n, ov;
    logic [31:0] b;
    n   = sgn && (((v >> 15) & 1) == 1);
    mag = n ? (65536 - v) : v;
    p10 = 1;
    for (int i = 0; i < digits; i++) p10 = p10 * 10;
    ov  = (mag >= p10);
    r   = mag % p10;
    b   = '0;
    for (int i = 0; i < digits; i++) begin
      b[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    lo = b[15:0];
    hi = b[31:16];
    st = {12'b0, ov, n, 1'b0, 1'b1};
  endtask

  task automatic wait_done(output logic [15:0] s5, output logic [15:0] s4);
    int n = 0;
    do begin
      bus_read(A_STATUS, s5, s4);
      n++;
    end while (!s5[0] && n < 200);
  endtask

  task automatic check_result(input string tag, input int unsigned v, input bit sgn,
                              input logic [15:0] s5, input logic [15:0] s4);
    logic [15:0] lo, hi, st, r5, r4;
    model(v, sgn, 5, lo, hi, st);
    check({tag, "_status5"}, s5, st);
    bus_read(A_RES_LO, r5, r4);
    check({tag, "_reslo5"}, r5, lo);
    bus_read(A_RES_HI, r5, r4);
    check({tag, "_reshi5"}, r5, hi);
    model(v, sgn, 4, lo, hi, st);
    check({tag, "_status4"}, s4, st);
    bus_read(A_RES_LO, r5, r4);
    check({tag, "_reslo4"}, r4, lo);
    bus_read(A_RES_HI, r5, r4);
    check({tag, "_reshi4"}, r4, hi);
  endtask

  task automatic run_conv(input string tag, input int unsigned v, input bit sgn);
    logic [15:0] s5, s4;
    bus_write(A_DATA_LO, 16'(v));
    bus_write(A_CTRL, {14'b0, sgn, 1'b1});
    wait_done(s5, s4);
    check_result(tag, v, sgn, s5, s4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic [15:0] s5, s4, r5, r4;
  int nbusy, npoll;
  int unsigned rv;
  bit rs;

  initial begin
    reset = 1'b0; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; d_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", d_out, 16'h0000);
    check("rst_irq", {15'b0, irq}, 16'h0000);
    reset = 1'b1;
    @(posedge clk); #1;
    bus_read(A_STATUS, s5, s4);
    check("rst_status", s5, 16'h0000);
    bus_read(A_RES_LO, s5, s4);
    check("rst_reslo", s5, 16'h0000);

    // Conversion latency: busy visible for exactly BIN_W polls, then done.
    bus_write(A_DATA_LO, 16'd12);
    bus_write(A_CTRL, 16'h0001);
    nbusy = 0; npoll = 0;
    do begin
      bus_read(A_STATUS, s5, s4);
      if (s5[1]) nbusy++;
      npoll++;
    end while (!s5[0] && npoll < 100);
    check("t1_busy_polls", 16'(nbusy), 16'd16);
    check("t1_status", s5, 16'h0001);
    bus_read(A_RES_LO, r5, r4);
    check("t1_reslo", r5, 16'h0012);
    bus_read(A_STATUS, s5, s4);
    check("t1_status_cleared", s5, 16'h0000);

    run_conv("t2_65535", 65535, 1'b0);
    bus_read(A_RES_HI, r5, r4);
    check("t2_reshi_lit", r5, 16'h0006);

    run_conv("t3_fff4", 16'hFFF4, 1'b1);
    run_conv("t3_8000", 16'h8000, 1'b1);
    bus_read(A_RES_LO, r5, r4);
    check("t3_8000_reslo_lit", r5, 16'h2768);

    run_conv("t4_12345", 12345, 1'b0);
    bus_read(A_RES_LO, r5, r4);
    check("t4_dig4_reslo_lit", r4, 16'h2345);
    run_conv("t4_9999", 9999, 1'b0);
    run_conv("t4_10000", 10000, 1'b0);
    run_conv("t4_zero", 0, 1'b0);
    run_conv("t4_7fff_signed", 16'h7FFF, 1'b1);

    // Start while busy must be ignored, including the DATA change.
    bus_write(A_DATA_LO, 16'd1234);
    bus_write(A_CTRL, 16'h0001);
    repeat (5) @(posedge clk);
    #1;
    bus_write(A_DATA_LO, 16'd7);
    bus_write(A_CTRL, 16'h0001);
    wait_done(s5, s4);
    check_result("t5", 1234, 1'b0, s5, s4);
    repeat (40) @(posedge clk);
    #1;
    bus_read(A_STATUS, s5, s4);
    check("t5_single_done", s5, 16'h0000);

    // Reset in mid-conversion abandons it.
    bus_write(A_DATA_LO, 16'd4321);
    bus_write(A_CTRL, 16'h0005);
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b0;
    #2;
    check("t6_rst_dout", d_out, 16'h0000);
    check("t6_rst_irq", {15'b0, irq}, 16'h0000);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("t6_no_irq", {15'b0, irq}, 16'h0000);
    bus_read(A_STATUS, s5, s4);
    check("t6_status", s5, 16'h0000);
    bus_read(A_RES_LO, r5, r4);
    check("t6_reslo", r5, 16'h0000);
    run_conv("t6_fresh", 4321, 1'b0);

    // Interrupt follows done and drops with the STATUS read.
    bus_write(A_DATA_LO, 16'd99);
    bus_write(A_CTRL, 16'h0005);
    check("t6_irq_low_busy", {15'b0, irq}, 16'h0000);
    repeat (25) @(posedge clk);
    #1;
    check("t6_irq_high", {15'b0, irq}, 16'h0001);
    check("t6_irq4_high", {15'b0, irq4}, 16'h0001);
    bus_read(A_STATUS, s5, s4);
    check("t6_irq_status", s5, 16'h0001);
    check("t6_irq_cleared", {15'b0, irq}, 16'h0000);
    bus_write(A_CTRL, 16'h0000);

    for (int i = 0; i < 24; i++) begin
      rv = $urandom_range(0, 65535);
      rs = 1'($urandom_range(0, 1));
      run_conv($sformatf("rnd%0d", i), rv, rs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
